// File: rtl/pattern_gen_pkg.sv
// ----------------------------------------------------------------------------
// pattern_gen_pkg
//   Shared types for the pattern burst generator.
//   - pattern_mode_t : data pattern selected at burst start
//   - gen_state_t    : burst control FSM states
// ----------------------------------------------------------------------------
package pattern_gen_pkg;

   typedef enum logic [1:0] {
      PAT_CONST  = 2'd0,
      PAT_ROTATE = 2'd1,
      PAT_LFSR   = 2'd2,
      PAT_INCR   = 2'd3
   } pattern_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } gen_state_t;

endpackage : pattern_gen_pkg

// File: rtl/pattern_next_value.sv
// ----------------------------------------------------------------------------
// pattern_next_value
//   Purely combinational successor function for the burst data word.
//   Ports:
//     mode_i        : pattern mode (constant / rotate / LFSR / increment)
//     shift_right_i : rotate direction, 1 = right, 0 = left
//     data_i        : current beat value
//     data_o        : next beat value
//   LFSR and increment modes operate independently on each LFSR_WIDTH lane.
// ----------------------------------------------------------------------------
module pattern_next_value
   import pattern_gen_pkg::*;
#(
   parameter int unsigned               WIDTH      = 256,
   parameter int unsigned               LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-2:0]     LFSR_TAPS  = 31'h23000000
) (
   input  pattern_mode_t    mode_i,
   input  logic             shift_right_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int unsigned LANES = WIDTH / LFSR_WIDTH;

   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] incr_next;
   logic [WIDTH-1:0] rot_next;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [LFSR_WIDTH-1:0] lane;
      assign lane = data_i[l*LFSR_WIDTH +: LFSR_WIDTH];

      // Galois step: the shifted-out bit re-enters at the MSB and XORs the taps.
      assign lfsr_next[l*LFSR_WIDTH +: LFSR_WIDTH] =
         {lane[0], ({(LFSR_WIDTH-1){lane[0]}} & LFSR_TAPS) ^ lane[LFSR_WIDTH-1:1]};

      // Lane-local increment; the carry out of each lane is discarded.
      assign incr_next[l*LFSR_WIDTH +: LFSR_WIDTH] =
         lane + {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
   end

   assign rot_next = shift_right_i ? {data_i[0], data_i[WIDTH-1:1]}
                                   : {data_i[WIDTH-2:0], data_i[WIDTH-1]};

   always_comb begin
      data_o = data_i;
      unique case (mode_i)
         PAT_CONST:  data_o = data_i;
         PAT_ROTATE: data_o = rot_next;
         PAT_LFSR:   data_o = lfsr_next;
         PAT_INCR:   data_o = incr_next;
         default:    data_o = data_i;
      endcase
   end

endmodule : pattern_next_value

// File: rtl/pattern_burst_generator.sv
// ----------------------------------------------------------------------------
// pattern_burst_generator
//   Emits a burst of burst_length+1 beats on a valid/ready stream, starting
//   from a seed and advancing through the selected pattern on each accepted
//   beat. The final beat carries final_byte_mask as its strobe and has the
//   disabled bytes zeroed.
//   Ports:
//     clock, resetn    : clock, asynchronous active-low reset
//     start            : launch a burst (IDLE only)
//     abort            : cancel the running burst, no done pulse
//     mode             : 0 const, 1 rotate, 2 LFSR, 3 increment
//     shift_direction  : rotate direction, 1 = right
//     seed             : first beat value
//     burst_length     : beats minus one
//     final_byte_mask  : byte enables for the last beat
//     out_valid/ready  : stream handshake
//     out_data/strb    : beat payload and byte enables
//     out_last         : final beat marker
//     busy             : burst in progress
//     done             : single-cycle pulse after the last beat is accepted
//   All outputs derive from registered state only.
// ----------------------------------------------------------------------------
module pattern_burst_generator
   import pattern_gen_pkg::*;
#(
   parameter int unsigned           WIDTH      = 256,
   parameter int unsigned           LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-2:0] LFSR_TAPS  = 31'h23000000,
   parameter int unsigned           LEN_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [1:0]           mode,
   input  logic                 shift_direction,
   input  logic [WIDTH-1:0]     seed,
   input  logic [LEN_WIDTH-1:0] burst_length,
   input  logic [WIDTH/8-1:0]   final_byte_mask,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [WIDTH/8-1:0]   out_strb,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned BYTES = WIDTH / 8;

   gen_state_t           state_q;
   pattern_mode_t        mode_q;
   logic                 shift_right_q;
   logic [BYTES-1:0]     mask_q;
   logic [LEN_WIDTH-1:0] remaining_q;
   logic [WIDTH-1:0]     data_q;
   logic [WIDTH-1:0]     data_d;
   logic                 out_valid_q;
   logic                 busy_q;
   logic                 done_q;

   pattern_next_value #(
      .WIDTH      (WIDTH),
      .LFSR_WIDTH (LFSR_WIDTH),
      .LFSR_TAPS  (LFSR_TAPS)
   ) u_next (
      .mode_i        (mode_q),
      .shift_right_i (shift_right_q),
      .data_i        (data_q),
      .data_o        (data_d)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         mode_q        <= PAT_CONST;
         shift_right_q <= 1'b0;
         mask_q        <= '0;
         remaining_q   <= '0;
         data_q        <= '0;
         out_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q        <= pattern_mode_t'(mode);
                  shift_right_q <= shift_direction;
                  mask_q        <= final_byte_mask;
                  remaining_q   <= burst_length;
                  data_q        <= seed;
                  out_valid_q   <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= RUN;
               end
            end
            RUN: begin
               // Abort wins over a handshake in the same cycle.
               if (abort) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else if (out_ready) begin
                  if (remaining_q == '0) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     remaining_q <= remaining_q - 1'b1;
                     data_q      <= data_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_last  = out_valid_q && (remaining_q == '0);

   // Strobe is zero outside a burst so the idle/reset data bus reads as zero.
   always_comb begin
      out_strb = '0;
      if (out_valid_q) begin
         out_strb = out_last ? mask_q : '1;
      end
   end

   always_comb begin
      out_data = '0;
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (out_strb[b]) begin
            out_data[b*8 +: 8] = data_q[b*8 +: 8];
         end
      end
   end

endmodule : pattern_burst_generator

// File: tb/tb_pattern_burst_generator.sv
// ----------------------------------------------------------------------------
// tb_pattern_burst_generator
//   Directed bench for pattern_burst_generator at WIDTH=64, LFSR_WIDTH=32.
// ----------------------------------------------------------------------------
module tb_pattern_burst_generator;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned LW    = 32;
   localparam int unsigned LEN   = 16;

   logic             clock = 1'b0;
   logic             resetn;
   logic             start;
   logic             abort;
   logic [1:0]       mode;
   logic             shift_direction;
   logic [WIDTH-1:0] seed;
   logic [LEN-1:0]   burst_length;
   logic [7:0]       final_byte_mask;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [7:0]       out_strb;
   logic             out_last;
   logic             busy;
   logic             done;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clock = ~clock;

   pattern_burst_generator #(
      .WIDTH      (WIDTH),
      .LFSR_WIDTH (LW),
      .LFSR_TAPS  (31'h23000000),
      .LEN_WIDTH  (LEN)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .start           (start),
      .abort           (abort),
      .mode            (mode),
      .shift_direction (shift_direction),
      .seed            (seed),
      .burst_length    (burst_length),
      .final_byte_mask (final_byte_mask),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_strb        (out_strb),
      .out_last        (out_last),
      .busy            (busy),
      .done            (done)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [63:0] d, input logic [7:0] s,
                           input logic l);
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " data"},  out_data, d);
      chk({tag, " strb"},  64'(out_strb), 64'(s));
      chk({tag, " last"},  64'(out_last), 64'(l));
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, " valid"}, 64'(out_valid), 64'd0);
      chk({tag, " busy"},  64'(busy), 64'd0);
      chk({tag, " done"},  64'(done), 64'(exp_done));
      chk({tag, " data"},  out_data, 64'd0);
      chk({tag, " strb"},  64'(out_strb), 64'd0);
   endtask

   task automatic launch(input logic [1:0] m, input logic dir, input logic [63:0] s,
                         input logic [LEN-1:0] len, input logic [7:0] msk);
      mode = m; shift_direction = dir; seed = s; burst_length = len;
      final_byte_mask = msk; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; shift_direction = 1'b0;
      seed = '0; burst_length = '0; final_byte_mask = '0; out_ready = 1'b0;
      tick(); tick();
      chk_idle("reset", 1'b0);
      chk("reset last", 64'(out_last), 64'd0);
      resetn = 1'b1;
      tick();

      // Constant burst, 4 beats, mask applied to the last only.
      out_ready = 1'b1;
      launch(2'd0, 1'b0, 64'h0123456789ABCDEF, 16'd3, 8'h0F);
      chk("const busy", 64'(busy), 64'd1);
      chk_beat("const b0", 64'h0123456789ABCDEF, 8'hFF, 1'b0); tick();
      chk_beat("const b1", 64'h0123456789ABCDEF, 8'hFF, 1'b0); tick();
      chk_beat("const b2", 64'h0123456789ABCDEF, 8'hFF, 1'b0); tick();
      chk_beat("const b3", 64'h0000000089ABCDEF, 8'h0F, 1'b1); tick();
      chk_idle("const done", 1'b1); tick();
      chk_idle("const after", 1'b0);

      // Rotate right with stalls; a start during RUN must be ignored.
      out_ready = 1'b0;
      launch(2'd1, 1'b1, 64'h1, 16'd2, 8'hFF);
      chk_beat("rot b0", 64'h1, 8'hFF, 1'b0);
      start = 1'b1; seed = 64'hDEADBEEFDEADBEEF; mode = 2'd3; burst_length = 16'd0;
      tick();
      start = 1'b0;
      chk_beat("rot b0 stall", 64'h1, 8'hFF, 1'b0);
      out_ready = 1'b1; tick();
      chk_beat("rot b1", 64'h8000000000000000, 8'hFF, 1'b0);
      out_ready = 1'b0; tick();
      chk_beat("rot b1 stall", 64'h8000000000000000, 8'hFF, 1'b0);
      out_ready = 1'b1; tick();
      chk_beat("rot b2", 64'h4000000000000000, 8'hFF, 1'b1);
      out_ready = 1'b0; tick();
      chk_beat("rot b2 stall", 64'h4000000000000000, 8'hFF, 1'b1);
      chk("rot stall done", 64'(done), 64'd0);
      out_ready = 1'b1; tick();
      chk_idle("rot done", 1'b1); tick();

      // Per-lane Galois LFSR.
      launch(2'd2, 1'b0, {32'h1, 32'h1}, 16'd1, 8'hFF);
      chk_beat("lfsr b0", {32'h1, 32'h1}, 8'hFF, 1'b0); tick();
      chk_beat("lfsr b1", {32'hA3000000, 32'hA3000000}, 8'hFF, 1'b1); tick();
      chk_idle("lfsr done", 1'b1); tick();

      // Per-lane increment with wrap, no carry between lanes.
      launch(2'd3, 1'b0, {32'h0, 32'hFFFFFFFF}, 16'd1, 8'hFF);
      chk_beat("incr b0", {32'h0, 32'hFFFFFFFF}, 8'hFF, 1'b0); tick();
      chk_beat("incr b1", {32'h1, 32'h0}, 8'hFF, 1'b1); tick();
      chk_idle("incr done", 1'b1); tick();

      // Abort with simultaneous handshake on beat 3 of a 10-beat burst.
      launch(2'd3, 1'b0, 64'h0, 16'd9, 8'hFF);
      chk_beat("abort b0", 64'h0, 8'hFF, 1'b0); tick();
      chk_beat("abort b1", {32'h1, 32'h1}, 8'hFF, 1'b0); tick();
      chk_beat("abort b2", {32'h2, 32'h2}, 8'hFF, 1'b0); tick();
      chk_beat("abort b3", {32'h3, 32'h3}, 8'hFF, 1'b0);
      abort = 1'b1; tick();
      abort = 1'b0;
      chk_idle("abort idle", 1'b0);
      chk("abort last", 64'(out_last), 64'd0);
      tick();
      chk_idle("abort no done", 1'b0);

      // Single-beat burst: last on the first beat.
      launch(2'd0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 16'd0, 8'h01);
      chk_beat("single b0", 64'h00000000000000FF, 8'h01, 1'b1); tick();
      chk_idle("single done", 1'b1); tick();

      // Reset mid-burst, then a fresh rotate-left burst.
      launch(2'd0, 1'b0, 64'h5555AAAA5555AAAA, 16'd5, 8'hFF);
      tick();
      chk_beat("rst pre", 64'h5555AAAA5555AAAA, 8'hFF, 1'b0);
      resetn = 1'b0; #1;
      chk_idle("rst async", 1'b0);
      chk("rst last", 64'(out_last), 64'd0);
      tick();
      resetn = 1'b1; tick();
      launch(2'd1, 1'b0, 64'h8000000000000001, 16'd1, 8'hFF);
      chk_beat("rotl b0", 64'h8000000000000001, 8'hFF, 1'b0); tick();
      chk_beat("rotl b1", 64'h0000000000000003, 8'hFF, 1'b1); tick();
      chk_idle("rotl done", 1'b1); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_pattern_burst_generator
